swi_debounce: RTL and testbench
===============================

// Module: swi_debounce
// PURPOSE
//   Conditions the eight raw board switches before they reach the combinational lab logic and the
//   LCD debug outputs in the top-level. Each bit is synchronised into clk_2 and debounced by its own
//   state machine. The block outputs the clean level plus single-cycle rise and fall pulses.
//   It sits directly upstream of the top-level: its swi_db output drives the SWI input there.
// PARAMETERS
//   NBITS            8   number of switch bits handled (matches NBITS_TOP)
//   DEBOUNCE_CYCLES  4   consecutive stable synchronised samples required to accept a change; legal range >= 2
//   CNT_W  $clog2(DEBOUNCE_CYCLES)+1   counter width (localparam, derived, not overridable)
// PORTS
//   clk_2        in   1       single system clock; all state updates on its rising edge
//   reset_n      in   1       asynchronous, active-low reset
//   swi_raw      in   NBITS   raw switch pins, asynchronous to clk_2, may bounce
//   swi_db       out  NBITS   debounced switch level (drives top-level SWI)
//   swi_rise     out  NBITS   1-cycle pulse per bit when swi_db[i] goes 0->1
//   swi_fall     out  NBITS   1-cycle pulse per bit when swi_db[i] goes 1->0
//   swi_changed  out  1       |(swi_rise | swi_fall); registered with the pulses, not derived from them
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous, at any time including mid-count)
//   - Both synchroniser stages clear to 0.
//   - Every bit FSM goes to S_LOW and every counter clears to 0.
//   - swi_db, swi_rise, swi_fall and swi_changed are 0.
//   - After reset_n rises, a switch that is already high is accepted through the normal rise path,
//     producing one swi_rise pulse.
//   Synchroniser
//   - Two-flop chain per bit: sync1 <= swi_raw, then sync2 <= sync1.
//   - The FSM sees only sync2.
//   Per-bit FSM, with states S_LOW, S_WAIT_HI, S_HIGH and S_WAIT_LO:
//   - S_LOW: sync2=1 -> S_WAIT_HI, cnt<=1. Otherwise stay.
//   - S_WAIT_HI:
//     - sync2=0 -> S_LOW, cnt<=0. This rejects the glitch; no pulse is produced.
//     - sync2=1 and cnt==DEBOUNCE_CYCLES-1 -> S_HIGH, cnt<=0, swi_db<=1, swi_rise<=1 for one cycle.
//     - Otherwise cnt<=cnt+1.
//   - S_HIGH and S_WAIT_LO mirror S_LOW and S_WAIT_HI with the polarity swapped, and drive swi_fall.
//   - swi_db is 1 exactly in S_HIGH and S_WAIT_LO, and is registered.
//   Latency
//   - swi_raw changes before edge E0 and stays stable -> swi_db and the pulse update at edge E0+DEBOUNCE_CYCLES+1.
//   - With the default of 4, that is edge E0+5.
//   Pulses
//   - Registered; high for exactly one cycle, then 0 on the next edge.
//   - A rise and a fall on the same bit are never simultaneous.
//   Counter
//   - Saturates by construction: it never exceeds DEBOUNCE_CYCLES-1 and never wraps.
//   Independence
//   - Bits are fully independent.
//   - Any combination of bits may change in the same cycle; each bit pulses on its own schedule.
//   - swi_changed=1 if any bit pulses that cycle.
// STRUCTURE
//   Package swi_pkg:
//   - typedef enum logic [1:0] {S_LOW, S_WAIT_HI, S_HIGH, S_WAIT_LO} db_state_t
//   - localparam DEBOUNCE_DEFAULT = 4
//   Sub-module debounce_bit, one bit:
//   - Contains the synchroniser, the FSM and the counter.
//   - Ports: clk_2, reset_n, raw, db, rise, fall.
//   swi_debounce:
//   - Instantiates NBITS copies of debounce_bit in a generate loop.
//   - Registers swi_changed from the OR of the next-state pulses.
// TESTING
//   1. Reset with swi_raw=8'h00 -> all outputs 0. Drive swi_raw=8'h01 before E0 -> swi_db=8'h01 and
//      swi_rise=8'h01 at edge E0+5, both pulses and swi_changed back to 0 at E0+6.
//   2. Bounce: swi_raw[3] toggles 1,0,1,0 on successive cycles, then holds 1 -> no pulse during the
//      bounce; a single rise pulse 5 edges after the last toggle.
//   3. Glitch: swi_raw[5] high for 3 cycles, then low -> swi_db stays 8'h00; swi_rise, swi_fall and
//      swi_changed stay 0 throughout.
//   4. Simultaneous: swi_raw 8'h0F->8'hF0 at one edge -> swi_rise=8'hF0 and swi_fall=8'h0F in the same
//      cycle, swi_db=8'hF0, swi_changed=1 for one cycle.
//   5. Reset mid-count: assert reset_n=0 during S_WAIT_HI -> outputs 0 immediately (asynchronous).
//      Release with swi_raw=8'h80 held -> swi_rise[7] pulses 5 edges after the first post-release edge.
//   6. Parameter sweep DEBOUNCE_CYCLES=2 and 16 -> latency is DEBOUNCE_CYCLES+1 edges; a glitch of
//      DEBOUNCE_CYCLES-1 cycles is rejected.

Source files
------------

// File: rtl/swi_pkg.sv
// Shared types and defaults for the switch debounce slice.
package swi_pkg;

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_WAIT_LO = 2'd3
    } db_state_t;

    localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/swi_debounce_bit.sv
// One switch bit: two-flop synchroniser, four-state debounce FSM, stability counter.
// pulse_d is the next-state rise|fall so the parent can register an aggregate flag alongside the pulses.
module debounce_bit
    import swi_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk_2,
    input  logic reset_n,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic pulse_d
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync2_q;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            S_LOW: begin
                if (sync2_q) begin
                    state_d = S_WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            S_WAIT_HI: begin
                if (!sync2_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync2_q) begin
                    state_d = S_WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            S_WAIT_LO: begin
                // Bouncing back high cancels the fall; db never dropped.
                if (sync2_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
                db_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db      = db_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign pulse_d = rise_d | fall_d;

endmodule

// File: rtl/swi_debounce.sv
// Debounces the board switch bank: one independent debounce_bit per switch plus a
// registered "any bit pulsed" flag aligned with the per-bit pulses.
module swi_debounce
    import swi_pkg::*;
#(
    parameter int NBITS           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic [NBITS-1:0] swi_raw,
    output logic [NBITS-1:0] swi_db,
    output logic [NBITS-1:0] swi_rise,
    output logic [NBITS-1:0] swi_fall,
    output logic             swi_changed
);

    logic [NBITS-1:0] pulse_d;
    logic             changed_q;

    for (genvar i = 0; i < NBITS; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_2  (clk_2),
            .reset_n(reset_n),
            .raw    (swi_raw[i]),
            .db     (swi_db[i]),
            .rise   (swi_rise[i]),
            .fall   (swi_fall[i]),
            .pulse_d(pulse_d[i])
        );
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |pulse_d;
        end
    end

    assign swi_changed = changed_q;

endmodule

// File: tb/tb_swi_debounce.sv
// Directed bench for swi_debounce: latency, bounce, glitch, simultaneous edges,
// asynchronous reset mid-count, and DEBOUNCE_CYCLES of 2 and 16.
module tb_swi_debounce;

    logic       clk_2;
    logic       reset_n;
    logic [7:0] swi_raw;

    logic [7:0] db4, rise4, fall4;
    logic       chg4;
    logic [7:0] db2, rise2, fall2;
    logic       chg2;
    logic [7:0] db16, rise16, fall16;
    logic       chg16;

    int n_cmp = 0;
    int n_bad = 0;

    swi_debounce #(.NBITS(8), .DEBOUNCE_CYCLES(4)) dut (
        .clk_2(clk_2), .reset_n(reset_n), .swi_raw(swi_raw),
        .swi_db(db4), .swi_rise(rise4), .swi_fall(fall4), .swi_changed(chg4)
    );

    swi_debounce #(.NBITS(8), .DEBOUNCE_CYCLES(2)) dut_c2 (
        .clk_2(clk_2), .reset_n(reset_n), .swi_raw(swi_raw),
        .swi_db(db2), .swi_rise(rise2), .swi_fall(fall2), .swi_changed(chg2)
    );

    swi_debounce #(.NBITS(8), .DEBOUNCE_CYCLES(16)) dut_c16 (
        .clk_2(clk_2), .reset_n(reset_n), .swi_raw(swi_raw),
        .swi_db(db16), .swi_rise(rise16), .swi_fall(fall16), .swi_changed(chg16)
    );

    // clock / reset
    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    // checking
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // driver: wait n rising edges, then step 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic chk_quiet4(input string tag, input logic [7:0] exp_db);
        chk({tag, " db"}, db4, exp_db);
        chk({tag, " rise"}, rise4, 8'h00);
        chk({tag, " fall"}, fall4, 8'h00);
        chk({tag, " chg"}, chg4, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        swi_raw = 8'h00;
        tick(2);
        chk_quiet4("reset", 8'h00);
        chk("reset db16", db16, 8'h00);
        reset_n = 1'b1;
        tick(3);

        // 1: single bit rise, latency 5 edges
        swi_raw = 8'h01;
        tick(5);
        chk_quiet4("t1 E0+4", 8'h00);
        tick(1);
        chk("t1 E0+5 db", db4, 8'h01);
        chk("t1 E0+5 rise", rise4, 8'h01);
        chk("t1 E0+5 fall", fall4, 8'h00);
        chk("t1 E0+5 chg", chg4, 1'b1);
        tick(1);
        chk_quiet4("t1 E0+6", 8'h01);

        // 2: bounce on bit 3, then hold high
        for (int k = 0; k < 5; k++) begin
            swi_raw[3] = (k % 2 == 0);
            tick(1);
            chk_quiet4("t2 bounce", 8'h01);
        end
        for (int k = 1; k < 5; k++) begin
            tick(1);
            chk_quiet4("t2 settle", 8'h01);
        end
        tick(1);
        chk("t2 db", db4, 8'h09);
        chk("t2 rise", rise4, 8'h08);
        chk("t2 chg", chg4, 1'b1);
        tick(1);
        chk_quiet4("t2 after", 8'h09);

        // 3: three-cycle glitch on bit 5 is rejected
        swi_raw = 8'h29;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk_quiet4("t3 high", 8'h09);
        end
        swi_raw = 8'h09;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk_quiet4("t3 low", 8'h09);
        end

        // 4: 0F -> F0 in one step
        swi_raw = 8'h0F;
        tick(8);
        chk_quiet4("t4 pre", 8'h0F);
        swi_raw = 8'hF0;
        tick(5);
        chk_quiet4("t4 E0+4", 8'h0F);
        tick(1);
        chk("t4 db", db4, 8'hF0);
        chk("t4 rise", rise4, 8'hF0);
        chk("t4 fall", fall4, 8'h0F);
        chk("t4 chg", chg4, 1'b1);
        tick(1);
        chk_quiet4("t4 after", 8'hF0);

        // 5: asynchronous reset while bit 0 sits in S_WAIT_HI
        swi_raw = 8'hF1;
        tick(3);
        reset_n = 1'b0;
        #2;
        chk_quiet4("t5 async", 8'h00);
        swi_raw = 8'h80;
        tick(2);
        chk_quiet4("t5 held", 8'h00);
        @(negedge clk_2);
        reset_n = 1'b1;
        tick(5);
        chk_quiet4("t5 E0+4", 8'h00);
        tick(1);
        chk("t5 db", db4, 8'h80);
        chk("t5 rise", rise4, 8'h80);
        chk("t5 chg", chg4, 1'b1);
        tick(1);
        chk_quiet4("t5 after", 8'h80);

        // 6: latency sweep across DEBOUNCE_CYCLES = 2, 4, 16
        reset_n = 1'b0;
        swi_raw = 8'h00;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        swi_raw = 8'h01;
        for (int j = 0; j < 19; j++) begin
            tick(1);
            chk($sformatf("t6 c2 db j%0d", j), db2, (j >= 3) ? 8'h01 : 8'h00);
            chk($sformatf("t6 c2 rise j%0d", j), rise2, (j == 3) ? 8'h01 : 8'h00);
            chk($sformatf("t6 c4 db j%0d", j), db4, (j >= 5) ? 8'h01 : 8'h00);
            chk($sformatf("t6 c4 rise j%0d", j), rise4, (j == 5) ? 8'h01 : 8'h00);
            chk($sformatf("t6 c16 db j%0d", j), db16, (j >= 17) ? 8'h01 : 8'h00);
            chk($sformatf("t6 c16 rise j%0d", j), rise16, (j == 17) ? 8'h01 : 8'h00);
            chk($sformatf("t6 c16 chg j%0d", j), chg16, (j == 17) ? 1'b1 : 1'b0);
        end
        swi_raw = 8'h00;
        tick(20);
        chk("t6 low c2", db2, 8'h00);
        chk("t6 low c4", db4, 8'h00);
        chk("t6 low c16", db16, 8'h00);

        swi_raw = 8'h01;
        tick(1);
        swi_raw = 8'h00;
        for (int j = 0; j < 8; j++) begin
            tick(1);
            chk("t6 c2 glitch db", db2, 8'h00);
            chk("t6 c2 glitch chg", chg2, 1'b0);
        end

        swi_raw = 8'h01;
        for (int j = 0; j < 40; j++) begin
            if (j == 15) swi_raw = 8'h00;
            tick(1);
            chk("t6 c16 glitch db", db16, 8'h00);
            chk("t6 c16 glitch rise", rise16, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
